// File: rtl/spi_mux_master.sv
// -----------------------------------------------------------------------------
// spi_mux_master
//
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first) driving the LED output
// multiplexer's SPI slave port. Bytes arrive on a valid/ready stream and are
// serialised onto spi_ncs_o/spi_sck_o/spi_mosi_o. Chip select stays low across
// a burst until a byte flagged last has been shifted. spi_miso_i is sampled on
// every rising SCK edge and the received byte is returned once per byte.
//
// Parameters:
//   HALF_CYC  - clk cycles per SCK half-period (>=1)
//   SETUP_CYC - clk cycles from nCS falling to the first SCK rising edge (>=1)
//   HOLD_CYC  - clk cycles from the last SCK falling edge to nCS rising (>=1)
//   GAP_CYC   - minimum clk cycles nCS stays high between frames (>=1)
//
// Ports:
//   clk_i       system clock, sole clock domain
//   reset_i     synchronous, active-high reset
//   tx_data_i   byte to transmit
//   tx_last_i   final byte of the frame (sampled only on accept)
//   tx_valid_i  tx_data_i/tx_last_i valid
//   tx_ready_o  byte accepted this cycle when tx_valid_i=1
//   rx_data_o   byte shifted in from spi_miso_i, held until the next byte
//   rx_valid_o  one-cycle pulse, rx_data_o updated
//   busy_o      high from accept until the inter-frame gap ends
//   spi_ncs_o   chip select, active low
//   spi_sck_o   serial clock, idle low
//   spi_mosi_o  serial data out
//   spi_miso_i  serial data in (already synchronised or tied off externally)
// -----------------------------------------------------------------------------
module spi_mux_master #(
  parameter int unsigned HALF_CYC  = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       spi_ncs_o,
  output logic       spi_sck_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
);

  localparam int unsigned MAX_HS  = (HALF_CYC > SETUP_CYC) ? HALF_CYC : SETUP_CYC;
  localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_HS > MAX_HG) ? MAX_HS : MAX_HG;
  // The counter holds duration-1 down to 0, so it only needs to reach MAX_CYC-1.
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SCK_LO, SCK_HI, WAIT, HOLD, GAP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_zero;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       tx_shift_q;
  logic [7:0]       rx_shift_q;
  logic             last_q;

  logic             tx_ready_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             busy_q;
  logic             ncs_q;
  logic             sck_q;
  logic             mosi_q;

  // Down-count of the current phase; a phase ends on the cycle cnt_q is zero.
  assign cnt_zero = (cnt_q == '0);
  assign cnt_d    = cnt_q - CNT_W'(1);

  // NOTE: every register in this block, including the shift registers, is
  // assigned with <= so all of them see pre-edge values; blocking assignments
  // here would make the result depend on statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      last_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ncs_q      <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid_i && tx_ready_q) begin
            tx_shift_q <= tx_data_i;
            last_q     <= tx_last_i;
            mosi_q     <= tx_data_i[7];
            ncs_q      <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            cnt_q      <= SETUP_LD;
            state_q    <= SETUP;
          end else begin
            // Comes up one cycle after reset release.
            tx_ready_q <= 1'b1;
          end
        end

        SETUP, SCK_LO: begin
          if (cnt_zero) begin
            // Rising edge: capture MISO in the same cycle SCK goes high.
            sck_q      <= 1'b1;
            rx_shift_q <= {rx_shift_q[6:0], spi_miso_i};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            cnt_q      <= HALF_LD;
            state_q    <= SCK_HI;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        SCK_HI: begin
          if (cnt_zero) begin
            sck_q <= 1'b0;
            // After 8 rising edges the 3-bit counter has wrapped back to zero.
            if (bit_cnt_q == 3'd0) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              if (last_q) begin
                // The final falling edge is the first HOLD cycle.
                cnt_q   <= HOLD_LD;
                state_q <= HOLD;
              end else begin
                tx_ready_q <= 1'b1;
                state_q    <= WAIT;
              end
            end else begin
              mosi_q     <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              cnt_q      <= HALF_LD;
              state_q    <= SCK_LO;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        WAIT: begin
          // Unbounded: chip select is only released after a last byte.
          if (tx_valid_i && tx_ready_q) begin
            tx_shift_q <= tx_data_i;
            last_q     <= tx_last_i;
            mosi_q     <= tx_data_i[7];
            tx_ready_q <= 1'b0;
            cnt_q      <= HALF_LD;
            state_q    <= SCK_LO;
          end
        end

        HOLD: begin
          if (cnt_zero) begin
            ncs_q   <= 1'b1;
            cnt_q   <= GAP_LD;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        GAP: begin
          if (cnt_zero) begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign spi_ncs_o  = ncs_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_mux_master.sv
// -----------------------------------------------------------------------------
// tb_spi_mux_master
//
// Directed bench for spi_mux_master with HALF=2, SETUP=2, HOLD=2, GAP=4.
// MISO is either looped back from MOSI or driven by a small mode-0 slave model
// that shifts out a fixed byte. Outputs are sampled 1 ns after each rising clk
// edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_spi_mux_master;

  localparam int HALF  = 2;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_ncs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  spi_mux_master #(
    .HALF_CYC (HALF),
    .SETUP_CYC(SETUP),
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .tx_data_i (tx_data),
    .tx_last_i (tx_last),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .busy_o    (busy),
    .spi_ncs_o (spi_ncs),
    .spi_sck_o (spi_sck),
    .spi_mosi_o(spi_mosi),
    .spi_miso_i(spi_miso)
  );

  always #5 clk = ~clk;

  // MISO source: loopback or a mode-0 slave presenting slave_byte MSB first.
  logic       loop_mode = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         slave_idx = 0;
  logic       slave_bit;

  always @(negedge spi_ncs) slave_idx = 0;
  always @(negedge spi_sck) if (!spi_ncs) slave_idx = slave_idx + 1;

  always_comb begin
    slave_bit = 1'b0;
    if (slave_idx < 8) slave_bit = slave_byte[3'(7 - slave_idx)];
  end

  assign spi_miso = loop_mode ? spi_mosi : slave_bit;

  // Bookkeeping
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rises    = 0;
  int         ncs_rises = 0;
  int         ncs_falls = 0;
  int         ncs_rise_cyc = 0;
  int         mosi_hi  = 0;
  int         hs       = 0;
  logic       sck_prev = 1'b0;
  logic       ncs_prev = 1'b1;
  logic [7:0] rxq[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clk cycle and record observed events.
  task automatic step();
    if (tx_valid && tx_ready) hs++;
    @(posedge clk);
    #1;
    cyc++;
    if (!sck_prev && spi_sck) rises++;
    if (spi_ncs && !ncs_prev) begin
      ncs_rises++;
      ncs_rise_cyc = cyc;
    end
    if (!spi_ncs && ncs_prev) ncs_falls++;
    if (rx_valid) rxq.push_back(rx_data);
    if (!spi_ncs && spi_mosi) mosi_hi++;
    sck_prev = spi_sck;
    ncs_prev = spi_ncs;
  endtask

  task automatic clear_obs();
    rises     = 0;
    ncs_rises = 0;
    ncs_falls = 0;
    mosi_hi   = 0;
    hs        = 0;
    rxq.delete();
  endtask

  // Wait for tx_ready, present one byte for one cycle.
  task automatic send(input logic [7:0] d, input logic l, input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      step();
      n++;
    end
    chki({tag, "_ready_timeout"}, int'(n < 200), 1);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    // tx_last is only meaningful on the accept cycle; leave it high to show that.
    tx_last  = 1'b1;
    tx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chki({tag, "_idle_timeout"}, int'(n < 400), 1);
  endtask

  initial begin
    int c0;
    int c;
    int n;
    logic [7:0] pat;

    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    tx_valid = 1'b0;
    step();
    step();

    // Reset state
    chk1("rst_ncs",      spi_ncs,  1'b1);
    chk1("rst_sck",      spi_sck,  1'b0);
    chk1("rst_mosi",     spi_mosi, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk8("rst_rx_data",  rx_data,  8'h00);
    chk1("rst_busy",     busy,     1'b0);

    reset = 1'b0;
    step();
    chk1("post_rst_tx_ready", tx_ready, 1'b1);
    sck_prev = spi_sck;
    ncs_prev = spi_ncs;

    // ---- Test 1: single byte 0xA5, exact cycle timing (loopback) ----
    clear_obs();
    pat      = 8'hA5;
    c0       = cyc;
    tx_data  = pat;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) tx_valid = 1'b0;
      c = cyc - c0;
      chk1($sformatf("t1_ncs_c%0d", c), spi_ncs, (c >= 1 && c <= 34) ? 1'b0 : 1'b1);
      chk1($sformatf("t1_sck_c%0d", c), spi_sck,
           (c >= 3 && c <= 32 && ((c - 3) % 4) < 2) ? 1'b1 : 1'b0);
      chk1($sformatf("t1_rxv_c%0d", c), rx_valid, (c == 33) ? 1'b1 : 1'b0);
      chk1($sformatf("t1_rdy_c%0d", c), tx_ready, (c >= 39) ? 1'b1 : 1'b0);
      chk1($sformatf("t1_busy_c%0d", c), busy, (c <= 38) ? 1'b1 : 1'b0);
      if (c >= 3 && c <= 31 && ((c - 3) % 4) == 0)
        chk1($sformatf("t1_mosi_rise%0d", (c - 3) / 4), spi_mosi, pat[3'(7 - (c - 3) / 4)]);
      if (c == 33) chk8("t1_rx_data", rx_data, 8'hA5);
    end
    chki("t1_rises", rises, 8);

    // ---- Test 2: loopback burst 0x01, 0x80, 0xFF ----
    clear_obs();
    send(8'h01, 1'b0, "t2_b0");
    send(8'h80, 1'b0, "t2_b1");
    send(8'hFF, 1'b1, "t2_b2");
    wait_idle("t2");
    chki("t2_rises",     rises,      24);
    chki("t2_ncs_falls", ncs_falls,  1);
    chki("t2_ncs_rises", ncs_rises,  1);
    chki("t2_rx_count",  rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk8("t2_rx0", rxq[0], 8'h01);
      chk8("t2_rx1", rxq[1], 8'h80);
      chk8("t2_rx2", rxq[2], 8'hFF);
    end

    // ---- Test 3: 10-cycle stall in WAIT ----
    clear_obs();
    send(8'h5A, 1'b0, "t3_b0");
    n = 0;
    while (!rx_valid && n < 200) begin
      step();
      n++;
    end
    chki("t3_rxv_timeout", int'(n < 200), 1);
    chk1("t3_rdy_with_rxv", tx_ready, 1'b1);
    chk8("t3_rx0", rx_data, 8'h5A);
    for (int k = 0; k < 10; k++) begin
      step();
      chk1($sformatf("t3_wait_ncs%0d", k), spi_ncs,  1'b0);
      chk1($sformatf("t3_wait_sck%0d", k), spi_sck,  1'b0);
      chk1($sformatf("t3_wait_rdy%0d", k), tx_ready, 1'b1);
    end
    tx_data  = 8'hC3;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk1("t3_w1_sck",  spi_sck,  1'b0);
    chk1("t3_w1_rdy",  tx_ready, 1'b0);
    chk1("t3_w1_mosi", spi_mosi, 1'b1);
    step();
    chk1("t3_w2_sck",  spi_sck,  1'b0);
    step();
    chk1("t3_w3_sck",  spi_sck,  1'b1);
    wait_idle("t3");
    chki("t3_rx_count", rxq.size(), 2);
    if (rxq.size() == 2) chk8("t3_rx1", rxq[1], 8'hC3);

    // ---- Test 4: slave model returns 0x3C while sending 0x00 ----
    clear_obs();
    loop_mode  = 1'b0;
    slave_byte = 8'h3C;
    send(8'h00, 1'b1, "t4");
    wait_idle("t4");
    chki("t4_rx_count", rxq.size(), 1);
    if (rxq.size() == 1) chk8("t4_rx", rxq[0], 8'h3C);
    chki("t4_mosi_high_cycles", mosi_hi, 0);
    chki("t4_rises", rises, 8);
    loop_mode = 1'b1;

    // ---- Test 5: reset in the middle of a byte ----
    clear_obs();
    send(8'h96, 1'b1, "t5_b0");
    n = 0;
    while (rises < 4 && n < 200) begin
      step();
      n++;
    end
    chki("t5_rise_timeout", int'(n < 200), 1);
    reset = 1'b1;
    step();
    chk1("t5_rst_ncs",  spi_ncs,  1'b1);
    chk1("t5_rst_sck",  spi_sck,  1'b0);
    chk1("t5_rst_mosi", spi_mosi, 1'b0);
    chk1("t5_rst_rdy",  tx_ready, 1'b0);
    chk1("t5_rst_rxv",  rx_valid, 1'b0);
    chk1("t5_rst_busy", busy,     1'b0);
    chk8("t5_rst_rxd",  rx_data,  8'h00);
    reset = 1'b0;
    step();
    chk1("t5_rel_rdy", tx_ready, 1'b1);
    for (int k = 0; k < 20; k++) step();
    chki("t5_no_rxv", rxq.size(), 0);
    send(8'h69, 1'b1, "t5_b1");
    wait_idle("t5");
    chki("t5_rx_count", rxq.size(), 1);
    if (rxq.size() == 1) chk8("t5_rx", rxq[0], 8'h69);

    // ---- Test 6: tx_valid held through HOLD/GAP ----
    clear_obs();
    chk1("t6_start_rdy", tx_ready, 1'b1);
    tx_data  = 8'h11;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    step();
    tx_data  = 8'h22;
    tx_last  = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      step();
      n++;
    end
    chki("t6_ready_timeout", int'(n < 200), 1);
    chki("t6_hs_before_idle", hs, 1);
    chki("t6_gap_len", cyc - ncs_rise_cyc, GAP);
    chk1("t6_ncs_in_idle", spi_ncs, 1'b1);
    step();
    tx_valid = 1'b0;
    chki("t6_hs_after", hs, 2);
    chk1("t6_second_ncs", spi_ncs,  1'b0);
    chk1("t6_second_rdy", tx_ready, 1'b0);
    wait_idle("t6");
    chki("t6_hs_final", hs, 2);
    chki("t6_rx_count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk8("t6_rx0", rxq[0], 8'h11);
      chk8("t6_rx1", rxq[1], 8'h22);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard bound on total simulation time.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, observed cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
